// File: rtl/ps_issue_reg.sv
// Issue pipeline register behind the two-stage RS selector: two registered issue lanes,
// RS clear strobes, and occupancy tracking for the non-pipelined multiplier.
module ps_issue_reg #(
  parameter int WIDTH = 16,
  parameter int PAYLOAD_W = 64,
  parameter int MULT_LAT = 4,
  parameter int FUNC_W = 2,
  parameter logic [FUNC_W-1:0] FU_MULT = 2'd2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  logic [WIDTH-1:0]             gnt_stage_1,
  input  logic [FUNC_W-1:0]            func_1,
  input  logic [WIDTH-1:0]             gnt_stage_2,
  input  logic [FUNC_W-1:0]            func_2,
  input  logic [WIDTH*PAYLOAD_W-1:0]   rs_payload,
  input  logic                         fu_ready0,
  input  logic                         fu_ready1,
  output logic                         issue0_valid,
  output logic                         issue1_valid,
  output logic [FUNC_W-1:0]            issue0_func,
  output logic [FUNC_W-1:0]            issue1_func,
  output logic [PAYLOAD_W-1:0]         issue0_payload,
  output logic [PAYLOAD_W-1:0]         issue1_payload,
  output logic [$clog2(WIDTH)-1:0]     issue0_idx,
  output logic [$clog2(WIDTH)-1:0]     issue1_idx,
  output logic [WIDTH-1:0]             rs_clear,
  output logic                         mult_busy
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(MULT_LAT + 1);

  logic                 r_valid0, r_valid1;
  logic [FUNC_W-1:0]    r_func0, r_func1;
  logic [PAYLOAD_W-1:0] r_pay0, r_pay1;
  logic [IDX_W-1:0]     r_idx0, r_idx1;
  logic [CNT_W-1:0]     r_mult_cnt;

  logic [PAYLOAD_W-1:0] w_pay1, w_pay2;
  logic [IDX_W-1:0]     w_idx1, w_idx2;
  logic                 w_free0, w_free1;
  logic                 w_dep0;
  logic                 w_mult_ok;
  logic                 w_acc0, w_acc1;

  // Grants are one-hot-or-zero, so an AND-OR reduction is a plain mux.
  always_comb begin
    w_pay1 = '0;
    w_pay2 = '0;
    w_idx1 = '0;
    w_idx2 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pay1 = w_pay1 | (rs_payload[i*PAYLOAD_W +: PAYLOAD_W] & {PAYLOAD_W{gnt_stage_1[i]}});
      w_pay2 = w_pay2 | (rs_payload[i*PAYLOAD_W +: PAYLOAD_W] & {PAYLOAD_W{gnt_stage_2[i]}});
      w_idx1 = w_idx1 | (IDX_W'(i) & {IDX_W{gnt_stage_1[i]}});
      w_idx2 = w_idx2 | (IDX_W'(i) & {IDX_W{gnt_stage_2[i]}});
    end
  end

  // A held MULT blocks a new one even while departing; the counter covers the rest.
  assign w_free0   = !r_valid0 || fu_ready0;
  assign w_free1   = !r_valid1 || fu_ready1;
  assign w_dep0    = r_valid0 && fu_ready0;
  assign w_mult_ok = (func_1 != FU_MULT) ||
                     ((r_mult_cnt == '0) && !(r_valid0 && (r_func0 == FU_MULT)));
  assign w_acc0    = (|gnt_stage_1) && w_free0 && !squash && !reset && w_mult_ok;
  assign w_acc1    = (|gnt_stage_2) && w_free1 && !squash && !reset;

  assign rs_clear  = (gnt_stage_1 & {WIDTH{w_acc0}}) | (gnt_stage_2 & {WIDTH{w_acc1}});
  assign mult_busy = !reset && (r_mult_cnt != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid0   <= 1'b0;
      r_valid1   <= 1'b0;
      r_func0    <= '0;
      r_func1    <= '0;
      r_pay0     <= '0;
      r_pay1     <= '0;
      r_idx0     <= '0;
      r_idx1     <= '0;
      r_mult_cnt <= '0;
    end else begin
      if (squash) begin
        r_valid0 <= 1'b0;
      end else if (w_acc0) begin
        r_valid0 <= 1'b1;
        r_func0  <= func_1;
        r_pay0   <= w_pay1;
        r_idx0   <= w_idx1;
      end else if (fu_ready0) begin
        r_valid0 <= 1'b0;
      end

      if (squash) begin
        r_valid1 <= 1'b0;
      end else if (w_acc1) begin
        r_valid1 <= 1'b1;
        r_func1  <= func_2;
        r_pay1   <= w_pay2;
        r_idx1   <= w_idx2;
      end else if (fu_ready1) begin
        r_valid1 <= 1'b0;
      end

      // The FU has already taken a departing MULT, so squash does not affect the count.
      if (w_dep0 && (r_func0 == FU_MULT)) begin
        r_mult_cnt <= CNT_W'(MULT_LAT);
      end else if (r_mult_cnt != '0) begin
        r_mult_cnt <= r_mult_cnt - CNT_W'(1);
      end
    end
  end

  assign issue0_valid   = r_valid0;
  assign issue1_valid   = r_valid1;
  assign issue0_func    = r_func0;
  assign issue1_func    = r_func1;
  assign issue0_payload = r_pay0;
  assign issue1_payload = r_pay1;
  assign issue0_idx     = r_idx0;
  assign issue1_idx     = r_idx1;

endmodule

// File: tb/tb_ps_issue_reg.sv
// Self-checking bench for ps_issue_reg: expected lane contents are queued when a grant
// should be accepted and popped when the lane shows its registered op.
module tb_ps_issue_reg;

  localparam logic [1:0] FU_ALU  = 2'd0;
  localparam logic [1:0] FU_LD   = 2'd1;
  localparam logic [1:0] FU_MULT = 2'd2;

  typedef struct packed {
    logic [1:0]  func;
    logic [3:0]  idx;
    logic [63:0] pay;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          squash;
  logic [15:0]   gnt_stage_1, gnt_stage_2;
  logic [1:0]    func_1, func_2;
  logic [1023:0] rs_payload;
  logic          fu_ready0, fu_ready1;
  logic          issue0_valid, issue1_valid;
  logic [1:0]    issue0_func, issue1_func;
  logic [63:0]   issue0_payload, issue1_payload;
  logic [3:0]    issue0_idx, issue1_idx;
  logic [15:0]   rs_clear;
  logic          mult_busy;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e;
  int   testsRun = 0;
  int   testsFailed = 0;

  ps_issue_reg #(.WIDTH(16), .PAYLOAD_W(64), .MULT_LAT(4), .FUNC_W(2), .FU_MULT(2'd2)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .gnt_stage_1(gnt_stage_1), .func_1(func_1),
    .gnt_stage_2(gnt_stage_2), .func_2(func_2),
    .rs_payload(rs_payload), .fu_ready0(fu_ready0), .fu_ready1(fu_ready1),
    .issue0_valid(issue0_valid), .issue1_valid(issue1_valid),
    .issue0_func(issue0_func), .issue1_func(issue1_func),
    .issue0_payload(issue0_payload), .issue1_payload(issue1_payload),
    .issue0_idx(issue0_idx), .issue1_idx(issue1_idx),
    .rs_clear(rs_clear), .mult_busy(mult_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] slotPay(input int i);
    logic [15:0] s;
    s = 16'(i);
    return {16'hA5C3, s, ~s, s ^ 16'h5A5A};
  endfunction

  function automatic exp_t mkExp(input logic [1:0] f, input int idx);
    exp_t x;
    x.func = f;
    x.idx  = 4'(idx);
    x.pay  = slotPay(idx);
    return x;
  endfunction

  task automatic applyStimulus(input logic [15:0] g1, input logic [1:0] f1,
                               input logic [15:0] g2, input logic [1:0] f2,
                               input logic r0, input logic r1, input logic sq);
    gnt_stage_1 = g1; func_1 = f1;
    gnt_stage_2 = g2; func_2 = f2;
    fu_ready0 = r0; fu_ready1 = r1; squash = sq;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    applyStimulus(16'h0001, FU_MULT, 16'h0002, FU_ALU, 1'b1, 1'b1, 1'b0);
    testsRun++;
    if (rs_clear !== 16'h0 || mult_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_comb: got clr=%h busy=%b expected clr=0 busy=0", rs_clear, mult_busy);
    end
    tick; tick;
    testsRun++;
    if ({issue0_valid, issue1_valid, issue0_func, issue1_func, issue0_idx, issue1_idx,
         issue0_payload, issue1_payload} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got v=%b%b idx=%h/%h pay=%h/%h expected all 0",
               issue0_valid, issue1_valid, issue0_idx, issue1_idx, issue0_payload, issue1_payload);
    end
    reset = 1'b0;
    applyStimulus(16'h0, FU_ALU, 16'h0, FU_ALU, 1'b1, 1'b1, 1'b0);
    tick;
    testsRun++;
    if ({issue0_valid, issue1_valid, rs_clear, mult_busy} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL idle: got v=%b%b clr=%h busy=%b expected 0", issue0_valid, issue1_valid,
               rs_clear, mult_busy);
    end
  endtask

  task automatic test_independent;
    applyStimulus(16'h0004, FU_ALU, 16'h0100, FU_LD, 1'b1, 1'b1, 1'b0);
    testsRun++;
    if (rs_clear !== 16'h0104) begin
      testsFailed++;
      $display("[TB] FAIL indep_clear: got %h expected 0104", rs_clear);
    end
    q0.push_back(mkExp(FU_ALU, 2));
    q1.push_back(mkExp(FU_LD, 8));
    tick;
    applyStimulus(16'h0, FU_ALU, 16'h0, FU_ALU, 1'b1, 1'b1, 1'b0);
    testsRun++; e = q0.pop_front();
    if ({issue0_valid, issue0_func, issue0_idx, issue0_payload} !== {1'b1, e}) begin
      testsFailed++;
      $display("[TB] FAIL indep_lane0: got %h expected %h", {issue0_valid, issue0_func, issue0_idx, issue0_payload}, {1'b1, e});
    end
    testsRun++; e = q1.pop_front();
    if ({issue1_valid, issue1_func, issue1_idx, issue1_payload} !== {1'b1, e}) begin
      testsFailed++;
      $display("[TB] FAIL indep_lane1: got %h expected %h", {issue1_valid, issue1_func, issue1_idx, issue1_payload}, {1'b1, e});
    end
    tick;
    testsRun++;
    if ({issue0_valid, issue1_valid} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL indep_drain: got %b%b expected 00", issue0_valid, issue1_valid);
    end
  endtask

  task automatic test_backpressure;
    applyStimulus(16'h0, FU_ALU, 16'h0100, FU_ALU, 1'b1, 1'b1, 1'b0);
    q1.push_back(mkExp(FU_ALU, 8));
    tick;
    testsRun++; e = q1.pop_front();
    if ({issue1_valid, issue1_func, issue1_idx, issue1_payload} !== {1'b1, e}) begin
      testsFailed++;
      $display("[TB] FAIL bp_load: got %h expected %h", {issue1_valid, issue1_func, issue1_idx, issue1_payload}, {1'b1, e});
    end
    applyStimulus(16'h0, FU_ALU, 16'h0200, FU_ALU, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if (rs_clear !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL bp_reject: got %h expected 0000", rs_clear);
    end
    tick;
    testsRun++;
    if ({issue1_valid, issue1_func, issue1_idx, issue1_payload} !== {1'b1, mkExp(FU_ALU, 8)} ||
        rs_clear !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL bp_hold: got idx=%h v=%b clr=%h expected idx=8 v=1 clr=0", issue1_idx,
               issue1_valid, rs_clear);
    end
    applyStimulus(16'h0, FU_ALU, 16'h0200, FU_ALU, 1'b1, 1'b1, 1'b0);
    testsRun++;
    if (rs_clear !== 16'h0200) begin
      testsFailed++;
      $display("[TB] FAIL bp_release: got %h expected 0200", rs_clear);
    end
    q1.push_back(mkExp(FU_ALU, 9));
    tick;
    applyStimulus(16'h0, FU_ALU, 16'h0, FU_ALU, 1'b1, 1'b1, 1'b0);
    testsRun++; e = q1.pop_front();
    if ({issue1_valid, issue1_func, issue1_idx, issue1_payload} !== {1'b1, e}) begin
      testsFailed++;
      $display("[TB] FAIL bp_slot9: got %h expected %h", {issue1_valid, issue1_func, issue1_idx, issue1_payload}, {1'b1, e});
    end
    tick;
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(16'(1 << k), FU_ALU, 16'(1 << (k + 8)), FU_LD, 1'b1, 1'b1, 1'b0);
      testsRun++;
      if (rs_clear !== (16'(1 << k) | 16'(1 << (k + 8)))) begin
        testsFailed++;
        $display("[TB] FAIL b2b_clear[%0d]: got %h expected %h", k, rs_clear,
                 16'(1 << k) | 16'(1 << (k + 8)));
      end
      q0.push_back(mkExp(FU_ALU, k));
      q1.push_back(mkExp(FU_LD, k + 8));
      tick;
      testsRun++; e = q0.pop_front();
      if ({issue0_valid, issue0_func, issue0_idx, issue0_payload} !== {1'b1, e}) begin
        testsFailed++;
        $display("[TB] FAIL b2b_lane0[%0d]: got %h expected %h", k, {issue0_valid, issue0_func, issue0_idx, issue0_payload}, {1'b1, e});
      end
      testsRun++; e = q1.pop_front();
      if ({issue1_valid, issue1_func, issue1_idx, issue1_payload} !== {1'b1, e}) begin
        testsFailed++;
        $display("[TB] FAIL b2b_lane1[%0d]: got %h expected %h", k, {issue1_valid, issue1_func, issue1_idx, issue1_payload}, {1'b1, e});
      end
    end
    applyStimulus(16'h0, FU_ALU, 16'h0, FU_ALU, 1'b1, 1'b1, 1'b0);
    tick;
  endtask

  task automatic test_mult_spacing;
    applyStimulus(16'h0008, FU_MULT, 16'h0, FU_ALU, 1'b1, 1'b1, 1'b0);
    testsRun++;
    if (rs_clear !== 16'h0008) begin
      testsFailed++;
      $display("[TB] FAIL mult_first: got %h expected 0008", rs_clear);
    end
    q0.push_back(mkExp(FU_MULT, 3));
    tick;
    testsRun++; e = q0.pop_front();
    if ({issue0_valid, issue0_func, issue0_idx, issue0_payload} !== {1'b1, e}) begin
      testsFailed++;
      $display("[TB] FAIL mult_issue3: got %h expected %h", {issue0_valid, issue0_func, issue0_idx, issue0_payload}, {1'b1, e});
    end
    applyStimulus(16'h0020, FU_MULT, 16'h0, FU_ALU, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      testsRun++;
      if (rs_clear !== 16'h0 || mult_busy !== (k != 0)) begin
        testsFailed++;
        $display("[TB] FAIL mult_block[t+%0d]: got clr=%h busy=%b expected clr=0 busy=%b", k,
                 rs_clear, mult_busy, k != 0);
      end
      tick;
    end
    testsRun++;
    if (rs_clear !== 16'h0020 || mult_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mult_accept: got clr=%h busy=%b expected clr=0020 busy=0", rs_clear, mult_busy);
    end
    q0.push_back(mkExp(FU_MULT, 5));
    tick;
    applyStimulus(16'h0, FU_ALU, 16'h0, FU_ALU, 1'b1, 1'b1, 1'b0);
    testsRun++; e = q0.pop_front();
    if ({issue0_valid, issue0_func, issue0_idx, issue0_payload} !== {1'b1, e}) begin
      testsFailed++;
      $display("[TB] FAIL mult_issue5: got %h expected %h", {issue0_valid, issue0_func, issue0_idx, issue0_payload}, {1'b1, e});
    end
    repeat (6) tick;
  endtask

  task automatic test_squash;
    applyStimulus(16'h0002, FU_MULT, 16'h0400, FU_ALU, 1'b1, 1'b1, 1'b0);
    q0.push_back(mkExp(FU_MULT, 1));
    q1.push_back(mkExp(FU_ALU, 10));
    tick;
    testsRun++; e = q0.pop_front();
    if ({issue0_valid, issue0_func, issue0_idx, issue0_payload} !== {1'b1, e}) begin
      testsFailed++;
      $display("[TB] FAIL sq_lane0: got %h expected %h", {issue0_valid, issue0_func, issue0_idx, issue0_payload}, {1'b1, e});
    end
    testsRun++; e = q1.pop_front();
    if ({issue1_valid, issue1_func, issue1_idx, issue1_payload} !== {1'b1, e}) begin
      testsFailed++;
      $display("[TB] FAIL sq_lane1: got %h expected %h", {issue1_valid, issue1_func, issue1_idx, issue1_payload}, {1'b1, e});
    end
    applyStimulus(16'h0040, FU_ALU, 16'h0800, FU_LD, 1'b1, 1'b0, 1'b1);
    testsRun++;
    if (rs_clear !== 16'h0 || {issue0_valid, issue1_valid} !== 2'b11) begin
      testsFailed++;
      $display("[TB] FAIL sq_cycle: got clr=%h v=%b%b expected clr=0 v=11", rs_clear, issue0_valid, issue1_valid);
    end
    tick;
    applyStimulus(16'h0, FU_ALU, 16'h0, FU_ALU, 1'b1, 1'b1, 1'b0);
    testsRun++;
    if ({issue0_valid, issue1_valid} !== 2'b00 || mult_busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL sq_after: got v=%b%b busy=%b expected v=00 busy=1", issue0_valid, issue1_valid, mult_busy);
    end
    repeat (3) tick;
    testsRun++;
    if (mult_busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL sq_cnt_last: got busy=%b expected 1", mult_busy);
    end
    tick;
    testsRun++;
    if (mult_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL sq_cnt_done: got busy=%b expected 0", mult_busy);
    end
  endtask

  task automatic test_reset_mid;
    applyStimulus(16'h0008, FU_MULT, 16'h0, FU_ALU, 1'b1, 1'b1, 1'b0);
    q0.push_back(mkExp(FU_MULT, 3));
    tick;
    applyStimulus(16'h0, FU_ALU, 16'h0, FU_ALU, 1'b1, 1'b1, 1'b0);
    testsRun++; e = q0.pop_front();
    if ({issue0_valid, issue0_func, issue0_idx, issue0_payload} !== {1'b1, e}) begin
      testsFailed++;
      $display("[TB] FAIL rm_mult: got %h expected %h", {issue0_valid, issue0_func, issue0_idx, issue0_payload}, {1'b1, e});
    end
    tick; tick;
    applyStimulus(16'h0010, FU_ALU, 16'h1000, FU_ALU, 1'b1, 1'b1, 1'b0);
    testsRun++;
    if (rs_clear !== 16'h1010 || mult_busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rm_fill: got clr=%h busy=%b expected clr=1010 busy=1", rs_clear, mult_busy);
    end
    tick;
    reset = 1'b1;
    applyStimulus(16'h0080, FU_MULT, 16'h0, FU_ALU, 1'b0, 1'b0, 1'b0);
    testsRun++;
    if ({issue0_valid, issue1_valid} !== 2'b11 || rs_clear !== 16'h0 || mult_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rm_during: got v=%b%b clr=%h busy=%b expected v=11 clr=0 busy=0",
               issue0_valid, issue1_valid, rs_clear, mult_busy);
    end
    tick;
    testsRun++;
    if ({issue0_valid, issue1_valid, issue0_func, issue1_func, issue0_idx, issue1_idx,
         issue0_payload, issue1_payload, mult_busy} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL rm_zero: got v=%b%b idx=%h/%h busy=%b expected all 0",
               issue0_valid, issue1_valid, issue0_idx, issue1_idx, mult_busy);
    end
    reset = 1'b0;
    applyStimulus(16'h0080, FU_MULT, 16'h0, FU_ALU, 1'b1, 1'b1, 1'b0);
    testsRun++;
    if (rs_clear !== 16'h0080) begin
      testsFailed++;
      $display("[TB] FAIL rm_accept: got %h expected 0080", rs_clear);
    end
    q0.push_back(mkExp(FU_MULT, 7));
    tick;
    applyStimulus(16'h0, FU_ALU, 16'h0, FU_ALU, 1'b1, 1'b1, 1'b0);
    testsRun++; e = q0.pop_front();
    if ({issue0_valid, issue0_func, issue0_idx, issue0_payload} !== {1'b1, e}) begin
      testsFailed++;
      $display("[TB] FAIL rm_issue7: got %h expected %h", {issue0_valid, issue0_func, issue0_idx, issue0_payload}, {1'b1, e});
    end
    repeat (6) tick;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rs_payload[i*64 +: 64] = slotPay(i);
    test_reset();
    test_independent();
    test_backpressure();
    test_back_to_back();
    test_mult_spacing();
    test_squash();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
